time_entry_loader: RTL and testbench
====================================

# time_entry_loader

Keypad time-entry front end for the microwave timer. Accepts decoded key presses, shifts BCD digits into an MM:SS entry buffer, normalizes the seconds field, then writes the four digits into the timer down-counter chain with a one-cycle active-low load strobe. After the load it raises the run enable and watches the chain's zero indication to end the cook cycle. It drives the parallel-load side of the timer digits, while the down-counters consume that interface.

## Interface
Parameters:
- none; all widths are fixed to 4-bit BCD digits.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- Cn  in  1  asynchronous active-low reset (clear)
- key_valid  in  1  one-cycle pulse; key_code is valid in this cycle
- key_code  in  4  0–9 digit, 4'hA clear, 4'hB start, 4'hC–4'hF ignored
- timer_zero  in  1  high when every timer digit is zero (AND of counter zero flags)
- sec_units  out  4  BCD seconds units (entry buffer / load data)
- sec_tens  out  4  BCD seconds tens
- min_units  out  4  BCD minutes units
- min_tens  out  4  BCD minutes tens
- Cin  out  1  active-low parallel-load strobe to the timer chain
- start  out  1  run enable (counting enable) to the timer chain
- digit_count  out  3  digits entered, 0–4
- busy  out  1  high in NORM, LOAD, RUN

## Operation
- Reset (Cn low, asynchronous): state IDLE; all digit outputs 0; digit_count 0; Cin 1; start 0; busy 0.
- States: IDLE, ENTRY, NORM, LOAD, RUN.
- IDLE/ENTRY, digit key: shift left (min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=key); digit_count+1; state ENTRY. At digit_count==4, further digits are ignored.
- IDLE/ENTRY, clear key: buffer cleared, digit_count 0, state IDLE.
- ENTRY, start key: if the buffer is nonzero, go to NORM. If the buffer is 00:00, clear it and go to IDLE. Start in IDLE is ignored.
- NORM, one cycle: apply the seconds rule (see Configuration). The buffer holds the result.
- LOAD, one cycle: Cin=0. Digits are stable for the whole cycle. The timer loads on the edge that ends LOAD.
- RUN: start=1. Digit keys and start keys are ignored.
  - Clear key: start=0, buffer and digit_count cleared, go to IDLE.
  - timer_zero high (sampled in RUN): same as clear key.
  - timer_zero is not sampled in LOAD.
- Keys 4'hC–4'hF are ignored in every state. key_valid in NORM or LOAD is ignored.
- Simultaneous clear key and timer_zero in RUN: single transition to IDLE.

## Timing
- Key to buffer update: 1 cycle; the register updates on the edge that samples key_valid.
- Start key to Cin low: 2 cycles (start edge → NORM, NORM edge → LOAD).
- Cin low for exactly one cycle. start rises on the edge that ends LOAD.
- Stop latency: start falls on the edge that samples timer_zero or the clear key.
- Reset asserted mid-RUN or mid-LOAD: outputs return to reset values immediately, without waiting for a clock edge.

## Configuration
- ENTRY_NORMALIZE_EN defined, NORM step:
  - If sec_tens>5: sec_tens -= 6 and minutes += 1 (BCD carry min_units→min_tens).
  - If minutes would exceed 99, saturate to 99:59.
  - Example: 90 → 01:30; 99:99 → 99:59.
- ENTRY_NORMALIZE_EN undefined, NORM step: sec_tens>5 is clamped to 5, minutes unchanged. Example: 90 → 00:50.
- Both builds keep the same state sequence and the same latency.

## Test plan
- Reset mid-RUN: assert Cn → start=0, Cin=1, digits 0000, digit_count=0 without a clock edge.
- Keys 1,2,3,0, start → Cin low for one cycle with digits 1,2,3,0 (12:30), 2 cycles after the start pulse. start=1 the following cycle. timer_zero pulse → IDLE with buffer 0000.
- Keys 9,0, start:
  - ENTRY_NORMALIZE_EN defined → load 01:30.
  - ENTRY_NORMALIZE_EN undefined → load 00:50.
- Keys 9,9,9,9, start with ENTRY_NORMALIZE_EN → load 99:59. Fifth digit key 5 before start → ignored, digit_count stays 4.
- Start in IDLE and start after entering 0,0 → no Cin pulse, start stays 0, state IDLE.
- In RUN, press digit 7 and code 4'hE → no change. Clear key with timer_zero in the same cycle → start=0 next edge, single return to IDLE.

Source files
------------

// File: rtl/time_entry_loader.sv
// ---------------------------------------------------------------------------
// time_entry_loader
//
// Keypad time-entry front end for the microwave timer. Decoded key presses
// are shifted into an MM:SS BCD entry buffer. A start key normalises the
// seconds field, presents the four digits to the timer down-counter chain
// with a one-cycle active-low parallel-load strobe, then holds the run enable
// until the chain reports zero or the user presses clear.
//
// Build option:
//   ENTRY_NORMALIZE_EN  defined   : seconds tens above 5 carry into minutes,
//                                   saturating at 99:59.
//                       undefined : seconds tens above 5 clamp to 5,
//                                   minutes unchanged.
//
// Ports:
//   clk          system clock, rising edge
//   Cn           asynchronous active-low clear
//   key_valid    one-cycle key strobe
//   key_code     0-9 digit, A clear, B start, C-F ignored
//   timer_zero   all timer digits are zero
//   sec_units    BCD seconds units (entry buffer / load data)
//   sec_tens     BCD seconds tens
//   min_units    BCD minutes units
//   min_tens     BCD minutes tens
//   Cin          active-low parallel-load strobe to the timer chain
//   start        run enable to the timer chain
//   digit_count  number of digits entered, 0-4
//   busy         high while normalising, loading or running
// ---------------------------------------------------------------------------
module time_entry_loader (
   input  logic       clk,
   input  logic       Cn,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       timer_zero,
   output logic [3:0] sec_units,
   output logic [3:0] sec_tens,
   output logic [3:0] min_units,
   output logic [3:0] min_tens,
   output logic       Cin,
   output logic       start,
   output logic [2:0] digit_count,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ENTRY = 3'd1,
      ST_NORM  = 3'd2,
      ST_LOAD  = 3'd3,
      ST_RUN   = 3'd4
   } state_t;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_START = 4'hB;

   // Buffer layout: {min_tens, min_units, sec_tens, sec_units}
`ifdef ENTRY_NORMALIZE_EN
   // Seconds tens above 5 borrow 60 s and add one minute; BCD carry from
   // minutes units into tens, saturating the whole entry at 99:59.
   function automatic logic [15:0] norm_digits(input logic [15:0] b);
      logic [3:0] mt;
      logic [3:0] mu;
      logic [3:0] st;
      logic [3:0] su;
      logic [15:0] r;
      mt = b[15:12];
      mu = b[11:8];
      st = b[7:4];
      su = b[3:0];
      if (st > 4'd5) begin
         st = st - 4'd6;
         if (mu == 4'd9) begin
            if (mt == 4'd9) begin
               r = {4'd9, 4'd9, 4'd5, 4'd9};
            end else begin
               r = {mt + 4'd1, 4'd0, st, su};
            end
         end else begin
            r = {mt, mu + 4'd1, st, su};
         end
      end else begin
         r = b;
      end
      return r;
   endfunction
`else
   // Seconds tens above 5 are clamped to 5; minutes untouched.
   function automatic logic [15:0] norm_digits(input logic [15:0] b);
      logic [15:0] r;
      if (b[7:4] > 4'd5) begin
         r = {b[15:8], 4'd5, b[3:0]};
      end else begin
         r = b;
      end
      return r;
   endfunction
`endif

   state_t      state_r;
   state_t      state_s;
   logic [15:0] buf_r;
   logic [15:0] buf_s;
   logic [2:0]  cnt_r;
   logic [2:0]  cnt_s;
   logic        cin_r;
   logic        cin_s;
   logic        start_r;
   logic        start_s;
   logic        busy_r;
   logic        busy_s;

   logic        is_digit_s;
   logic        is_clear_s;
   logic        is_start_s;

   // Key decode; codes C-F fall through as no-ops everywhere.
   always_comb begin
      is_digit_s = key_valid && (key_code <= 4'd9);
      is_clear_s = key_valid && (key_code == KEY_CLEAR);
      is_start_s = key_valid && (key_code == KEY_START);
   end

   // Next-state, entry buffer and digit counter.
   always_comb begin
      state_s = state_r;
      buf_s   = buf_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE, ST_ENTRY: begin
            if (is_clear_s) begin
               buf_s   = 16'h0000;
               cnt_s   = 3'd0;
               state_s = ST_IDLE;
            end else if (is_digit_s) begin
               // A full buffer silently drops further digits.
               if (cnt_r < 3'd4) begin
                  buf_s   = {buf_r[11:0], key_code};
                  cnt_s   = cnt_r + 3'd1;
                  state_s = ST_ENTRY;
               end else begin
                  state_s = ST_ENTRY;
               end
            end else if (is_start_s && (state_r == ST_ENTRY)) begin
               // An all-zero entry is discarded rather than loaded.
               if (buf_r != 16'h0000) begin
                  state_s = ST_NORM;
               end else begin
                  buf_s   = 16'h0000;
                  cnt_s   = 3'd0;
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = state_r;
            end
         end
         ST_NORM: begin
            buf_s   = norm_digits(buf_r);
            state_s = ST_LOAD;
         end
         ST_LOAD: begin
            // timer_zero is deliberately ignored here: the chain still
            // holds its previous (possibly zero) count until this edge.
            state_s = ST_RUN;
         end
         ST_RUN: begin
            if (is_clear_s || timer_zero) begin
               buf_s   = 16'h0000;
               cnt_s   = 3'd0;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: begin
            buf_s   = 16'h0000;
            cnt_s   = 3'd0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output strobes decoded from the next state so they are registered.
   always_comb begin
      cin_s   = (state_s != ST_LOAD);
      start_s = (state_s == ST_RUN);
      busy_s  = (state_s == ST_NORM) || (state_s == ST_LOAD) ||
                (state_s == ST_RUN);
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge Cn) begin
      if (!Cn) begin
         state_r <= ST_IDLE;
         buf_r   <= 16'h0000;
         cnt_r   <= 3'd0;
         cin_r   <= 1'b1;
         start_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         buf_r   <= buf_s;
         cnt_r   <= cnt_s;
         cin_r   <= cin_s;
         start_r <= start_s;
         busy_r  <= busy_s;
      end
   end

   assign {min_tens, min_units, sec_tens, sec_units} = buf_r;
   assign digit_count = cnt_r;
   assign Cin         = cin_r;
   assign start       = start_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_time_entry_loader.sv
module tb_time_entry_loader;

   logic       clk;
   logic       Cn;
   logic       key_valid;
   logic [3:0] key_code;
   logic       timer_zero;
   logic [3:0] sec_units;
   logic [3:0] sec_tens;
   logic [3:0] min_units;
   logic [3:0] min_tens;
   logic       Cin;
   logic       start;
   logic [2:0] digit_count;
   logic       busy;

   int total = 0;
   int bad   = 0;

   // Reference model: the digits the user has entered (at most four).
   int ent_q[$];

   time_entry_loader dut (
      .clk         (clk),
      .Cn          (Cn),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .timer_zero  (timer_zero),
      .sec_units   (sec_units),
      .sec_tens    (sec_tens),
      .min_units   (min_units),
      .min_tens    (min_tens),
      .Cin         (Cin),
      .start       (start),
      .digit_count (digit_count),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_val();
      int v = 0;
      foreach (ent_q[i]) v = v * 10 + ent_q[i];
      return v;
   endfunction

   function automatic logic [15:0] to_bcd(input int mm, input int ss);
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   // Value the timer should receive, from plain minute/second arithmetic.
   function automatic logic [15:0] model_load(input int v);
      int mm = v / 100;
      int st = (v % 100) / 10;
      int su = v % 10;
`ifdef ENTRY_NORMALIZE_EN
      if (st > 5) begin
         st = st - 6;
         mm = mm + 1;
      end
      if (mm > 99) begin
         mm = 99;
         st = 5;
         su = 9;
      end
`else
      if (st > 5) st = 5;
`endif
      return to_bcd(mm, st * 10 + su);
   endfunction

   function automatic logic [15:0] digits();
      return {min_tens, min_units, sec_tens, sec_units};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] c);
      key_valid = 1'b1;
      key_code  = c;
      tick();
      key_valid = 1'b0;
      key_code  = 4'h0;
   endtask

   task automatic check_entry(input string tag);
      int v = model_val();
      check_val({tag, "_digits"}, 32'(digits()), 32'(to_bcd(v / 100, v % 100)));
      check_val({tag, "_count"}, 32'(digit_count), 32'(ent_q.size()));
      check_val({tag, "_cin"}, 32'(Cin), 32'd1);
      check_val({tag, "_start"}, 32'(start), 32'd0);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic do_digit(input int d);
      press(4'(d));
      if (ent_q.size() < 4) ent_q.push_back(d);
      check_entry("entry");
   endtask

   task automatic do_clear();
      press(4'hA);
      ent_q.delete();
      check_entry("clear");
   endtask

   // stop_mode: 0 timer_zero, 1 clear key, 2 both together, 3 async reset
   task automatic do_start(input int stop_mode, input bit zero_in_load);
      int v = model_val();
      int n = ent_q.size();
      logic [15:0] ld;
      press(4'hB);
      if (v == 0) begin
         ent_q.delete();
         for (int i = 0; i < 3; i++) begin
            check_entry("start_ignored");
            tick();
         end
         return;
      end
      check_val("norm_busy", 32'(busy), 32'd1);
      check_val("norm_cin", 32'(Cin), 32'd1);
      check_val("norm_start", 32'(start), 32'd0);
      ld = model_load(v);
      tick();
      check_val("load_cin", 32'(Cin), 32'd0);
      check_val("load_digits", 32'(digits()), 32'(ld));
      check_val("load_start", 32'(start), 32'd0);
      if (zero_in_load) timer_zero = 1'b1;
      tick();
      timer_zero = 1'b0;
      check_val("run_cin", 32'(Cin), 32'd1);
      check_val("run_start", 32'(start), 32'd1);
      check_val("run_digits", 32'(digits()), 32'(ld));
      check_val("run_count", 32'(digit_count), 32'(n));
      press(4'h7);
      press(4'hE);
      press(4'hB);
      check_val("run_keys_start", 32'(start), 32'd1);
      check_val("run_keys_digits", 32'(digits()), 32'(ld));
      check_val("run_keys_busy", 32'(busy), 32'd1);
      repeat ($urandom_range(0, 3)) tick();
      check_val("run_hold", 32'(start), 32'd1);
      ent_q.delete();
      case (stop_mode)
         0: begin
            timer_zero = 1'b1;
            tick();
            timer_zero = 1'b0;
         end
         1: press(4'hA);
         2: begin
            timer_zero = 1'b1;
            press(4'hA);
            timer_zero = 1'b0;
         end
         default: begin
            Cn = 1'b0;
            #2;
            check_entry("async_rst");
            @(posedge clk);
            #1;
            Cn = 1'b1;
         end
      endcase
      check_entry("stop");
      tick();
      check_entry("stop_settle");
   endtask

   initial begin
      Cn         = 1'b0;
      key_valid  = 1'b0;
      key_code   = 4'h0;
      timer_zero = 1'b0;
      repeat (2) tick();
      check_entry("reset");
      Cn = 1'b1;
      tick();
      check_entry("post_reset");

      // 12:30 load, stopped by timer_zero, with timer_zero held during LOAD
      do_digit(1); do_digit(2); do_digit(3); do_digit(0);
      do_start(0, 1'b1);

      // 90 -> 01:30 or 00:50 depending on build
      do_digit(9); do_digit(0);
      do_start(1, 1'b0);

      // 99:99 with a fifth digit ignored; clear and timer_zero together
      do_digit(9); do_digit(9); do_digit(9); do_digit(9); do_digit(5);
      do_start(2, 1'b0);

      // start in IDLE, then start after 0,0
      do_start(1, 1'b0);
      do_digit(0); do_digit(0);
      do_start(1, 1'b0);

      // reset mid-RUN
      do_digit(1); do_digit(2); do_digit(3); do_digit(0);
      do_start(3, 1'b0);

      // randomized sessions
      for (int it = 0; it < 40; it++) begin
         int n = $urandom_range(0, 6);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 5) == 0) begin
               press(4'($urandom_range(12, 15)));
               check_entry("ignored_code");
            end
            if ($urandom_range(0, 9) == 0) do_clear();
            do_digit($urandom_range(0, 9));
         end
         do_start($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
